reg_writeback: RTL
==================

# reg_writeback

Write-side companion to the 16x16 register file: collects results from the single-cycle ALU and the multi-cycle load unit, arbitrates them onto the file's single write port (RA/write_data/reg_write), and buffers ALU results that lose arbitration in a small FIFO. It also keeps a pending-load scoreboard and forwards the value being written this cycle to the read ports. The register file only commits at the next edge, so a same-cycle read would otherwise return stale data.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 4, register index width (2**ADDR_W registers; register 0 hardwired zero)
- FIFO_DEPTH, 2, ALU result buffer entries (power of two, >=2)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  result accepted when alu_valid && alu_ready
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- ld_issue  in  1  load dispatched this cycle; marks ld_issue_rd pending
- ld_issue_rd  in  ADDR_W  load destination
- ld_valid  in  1  load response; no backpressure, must be taken this cycle
- ld_rd  in  ADDR_W  response destination
- ld_data  in  DATA_W  response data
- RA  out  ADDR_W  register file write address (registered)
- write_data  out  DATA_W  register file write data (registered)
- reg_write  out  1  register file write enable (registered)
- RS1, RS2  in  ADDR_W  read indices also driven to the register file
- SR1_IN, SR2_IN  in  DATA_W  raw register file read data
- SR1_FWD, SR2_FWD  out  DATA_W  forwarded read data
- rs1_hazard, rs2_hazard  out  1  busy_mask[RS1]/busy_mask[RS2]
- busy_mask  out  2**ADDR_W  pending-load scoreboard

## Operation
- Arbitration each cycle, fixed priority: load response > FIFO head > incoming ALU result, when the FIFO is empty and the ALU result is accepted the same cycle.
- ALU results with alu_rd==0 are accepted and discarded. They are not queued and cause no write.
- Load responses with ld_rd==0 are discarded. The scoreboard is unaffected.
- The winner is registered into RA/write_data/reg_write at the next edge. With no winner, reg_write=0, and RA/write_data hold their previous values.
- FIFO: an accepted ALU result that is not the winner is pushed. Push and pop in the same cycle are legal.
- alu_ready = !full. When full, it also equals 1 if a pop occurs this cycle (pop-through). It is forced 0 while rst is high.
- Scoreboard: ld_issue with ld_issue_rd!=0 sets busy_mask[ld_issue_rd]. A winning ld_valid clears busy_mask[ld_rd] at the same edge as the output register load. If set and clear hit the same index in the same cycle, set wins. Bit 0 is always 0.
- ALU writes never touch busy_mask. Write-after-write ordering against pending loads is the issue stage's job, using the hazard outputs.
- Forwarding, combinational: SRx_FWD = write_data when reg_write && RA==RSx && RSx!=0. Otherwise SRx_FWD = SRx_IN.

## Timing
- Reset (async assert, sync deassert by the system): reg_write=0, RA=0, write_data=0, FIFO empty, busy_mask=0, alu_ready=0 during reset and 1 on the first cycle after.
- A reset mid-operation drops all queued results and pending bits.
- Latency: load response at cycle N gives reg_write=1 in cycle N+1, always.
- ALU result accepted at N with FIFO empty and no load gives a write in N+1. Each queued entry and each intervening load adds one cycle.
- Throughput: one register file write per cycle. A continuous load stream starves the FIFO; the ALU stalls once the FIFO is full.
- Forwarding applies in the cycle reg_write is high. From the next cycle on, the register file itself holds the value.

## Structure
- Shared package: DATA_W/ADDR_W defaults and a result record typedef {rd, data}, reused by the ALU and load unit.
- One sub-module: wb_fifo (parameterised sync FIFO with full/empty, push/pop, pop-through allowed). Arbitration, scoreboard and forwarding stay in reg_writeback.

## Test plan
- Reset: assert rst mid-stream with 2 FIFO entries and busy_mask=16'h0006. Required: reg_write=0, busy_mask=0, FIFO empty immediately; alu_ready=1 one cycle after release.
- Single ALU: alu rd=3, data=16'h1234 at cycle N with the FIFO empty. Required: RA=3, write_data=16'h1234, reg_write=1 in N+1; alu_rd=0 produces no write.
- Conflict: ld_valid rd=5 data=16'hAAAA held for 3 cycles while the ALU offers rd=1,2,3. Required: 3 load writes; alu_ready drops after 2 accepts; then rd=1,2,3 are written in order.
- Scoreboard: ld_issue rd=7 gives busy_mask[7]=1 and rs1_hazard=1 for RS1=7. ld_valid rd=7 clears the bit. Simultaneous ld_issue rd=7 and ld_valid rd=7 leaves busy_mask[7]=1.
- Forwarding: reg_write=1, RA=4, write_data=16'hBEEF, RS1=4, RS2=0, SR1_IN=16'h0000. Required: SR1_FWD=16'hBEEF, SR2_FWD=SR2_IN.
- Random soak: random ALU/load traffic against a reference model. Required: the write sequence matches the model; no result is lost or duplicated.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-file write side: default widths, the
// result record produced by the ALU and load unit, and the arbitration source.
package reg_writeback_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } result_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FIFO,
    SRC_ALU
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of the ALU, load-unit, register-file write and read-forwarding signals.
// The slave modport is the writeback block; the master modport is its environment.
interface reg_writeback_if #(
  parameter int DATA_W = reg_writeback_pkg::DEF_DATA_W,
  parameter int ADDR_W = reg_writeback_pkg::DEF_ADDR_W
);

  logic                 alu_valid;
  logic                 alu_ready;
  logic [ADDR_W-1:0]    alu_rd;
  logic [DATA_W-1:0]    alu_data;
  logic                 ld_issue;
  logic [ADDR_W-1:0]    ld_issue_rd;
  logic                 ld_valid;
  logic [ADDR_W-1:0]    ld_rd;
  logic [DATA_W-1:0]    ld_data;
  logic [ADDR_W-1:0]    RA;
  logic [DATA_W-1:0]    write_data;
  logic                 reg_write;
  logic [ADDR_W-1:0]    RS1;
  logic [ADDR_W-1:0]    RS2;
  logic [DATA_W-1:0]    SR1_IN;
  logic [DATA_W-1:0]    SR2_IN;
  logic [DATA_W-1:0]    SR1_FWD;
  logic [DATA_W-1:0]    SR2_FWD;
  logic                 rs1_hazard;
  logic                 rs2_hazard;
  logic [2**ADDR_W-1:0] busy_mask;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
    input  RS1, RS2, SR1_IN, SR2_IN,
    output alu_ready, RA, write_data, reg_write,
    output SR1_FWD, SR2_FWD, rs1_hazard, rs2_hazard, busy_mask
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
    output RS1, RS2, SR1_IN, SR2_IN,
    input  alu_ready, RA, write_data, reg_write,
    input  SR1_FWD, SR2_FWD, rs1_hazard, rs2_hazard, busy_mask
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Small synchronous FIFO for ALU results that lose write-port arbitration.
// Push and pop may happen in the same cycle, including push while full with a pop.
module wb_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; an entry is only read after the pointers say it was written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/reg_writeback.sv
// Arbitrates load responses, buffered and live ALU results onto the register file
// write port; tracks pending loads and forwards the in-flight write to the read ports.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic            clk,
  input logic            rst,
  reg_writeback_if.slave wb
);

  localparam int NREG = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

  wb_src_e           w_src;
  wb_rec_t           w_alu_rec;
  wb_rec_t           w_ld_rec;
  wb_rec_t           w_fifo_head;
  wb_rec_t           w_win;
  logic              w_alu_live;
  logic              w_ld_live;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [NREG-1:0]   w_busy_set;
  logic [NREG-1:0]   w_busy_clr;
  logic [ADDR_W-1:0] r_ra;
  logic [DATA_W-1:0] r_wd;
  logic              r_we;
  logic [NREG-1:0]   r_busy;

  assign w_alu_rec = {wb.alu_rd, wb.alu_data};
  assign w_ld_rec  = {wb.ld_rd, wb.ld_data};
  assign w_ld_live = wb.ld_valid && (wb.ld_rd != '0);

  // The FIFO head wins whenever no load does; computed ahead of alu_ready to keep
  // the ready path free of any dependence on alu_valid.
  assign w_pop        = !w_ld_live && !w_empty;
  assign wb.alu_ready = !rst && (!w_full || w_pop);
  assign w_alu_live   = wb.alu_valid && wb.alu_ready && (wb.alu_rd != '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_src = SRC_NONE;
    w_win = w_alu_rec;
    if (w_ld_live) begin
      w_src = SRC_LOAD;
      w_win = w_ld_rec;
    end else if (w_pop) begin
      w_src = SRC_FIFO;
      w_win = w_fifo_head;
    end else if (w_alu_live) begin
      w_src = SRC_ALU;
    end
  end

  assign w_push = w_alu_live && (w_src != SRC_ALU);

  wb_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_alu_rec),
    .o_data  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (wb.ld_issue && (wb.ld_issue_rd != '0)) w_busy_set[wb.ld_issue_rd] = 1'b1;
    if (w_src == SRC_LOAD)                     w_busy_clr[wb.ld_rd]       = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra   <= '0;
      r_wd   <= '0;
      r_we   <= 1'b0;
      r_busy <= '0;
    end else begin
      r_we <= (w_src != SRC_NONE);
      if (w_src != SRC_NONE) begin
        r_ra <= w_win.rd;
        r_wd <= w_win.data;
      end
      // Set is applied after clear so a same-index issue beats the response.
      r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & {{(NREG-1){1'b1}}, 1'b0};
    end
  end

  assign wb.RA         = r_ra;
  assign wb.write_data = r_wd;
  assign wb.reg_write  = r_we;
  assign wb.busy_mask  = r_busy;
  assign wb.rs1_hazard = r_busy[wb.RS1];
  assign wb.rs2_hazard = r_busy[wb.RS2];

  // The file commits at the next edge, so the value on the write port is bypassed.
  assign wb.SR1_FWD = (r_we && (r_ra == wb.RS1) && (wb.RS1 != '0)) ? r_wd : wb.SR1_IN;
  assign wb.SR2_FWD = (r_we && (r_ra == wb.RS2) && (wb.RS2 != '0)) ? r_wd : wb.SR2_IN;

endmodule
